// File: rtl/aes_round_sequencer.sv
// Iterative AES encrypt sequencer: holds the running state, steps the external round /
// last_round units through nr rounds and presents the ciphertext on a valid/ready port.
module aes_round_sequencer #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_data,
  input  logic [(nr+1)*128-1:0] w,
  output logic [127:0]          rnd_state,
  output logic [127:0]          rnd_key,
  input  logic [127:0]          rnd_out,
  input  logic [127:0]          lrnd_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_data,
  output logic                  busy,
  output logic [3:0]            round_idx
);
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_LAST, S_DONE} fsm_t;

  localparam logic [3:0] NR_M1 = 4'(nr - 1);

  fsm_t         r_fsm;
  logic [127:0] r_state;
  logic [3:0]   r_cnt;
  logic         r_out_valid;
  logic [127:0] r_out_data;
  logic         r_busy;
  logic         r_in_ready;
  logic [127:0] w_keys [0:nr];

  if (nr != nk + 6 || nr > 14) begin : g_bad_cfg
    $error("aes_round_sequencer: nr must equal nk+6 and be at most 14");
  end

  genvar gi;
  generate
    for (gi = 0; gi <= nr; gi++) begin : g_key
      assign w_keys[gi] = w[gi*128 +: 128];
    end
  endgenerate

  // r_cnt is also the round-key index: 0 in IDLE, the round number in ROUND, nr in LAST/DONE.
  assign rnd_key   = w_keys[r_cnt];
  assign rnd_state = r_state;
  assign round_idx = r_cnt;
  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm       <= S_IDLE;
      r_state     <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_state    <= in_data ^ w_keys[0];
            r_cnt      <= 4'd1;
            r_fsm      <= (nr == 1) ? S_LAST : S_ROUND;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b0;
          end
        end
        S_ROUND: begin
          r_state <= rnd_out;
          r_cnt   <= r_cnt + 4'd1;
          if (r_cnt == NR_M1) begin
            r_fsm <= S_LAST;
          end
        end
        S_LAST: begin
          r_out_data  <= lrnd_out;
          r_out_valid <= 1'b1;
          r_fsm       <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_fsm       <= S_IDLE;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: a behavioural AES round/last_round model stands in for the
// external datapath; results are checked against published AES known-answer ciphertexts.
module tb_aes_round_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [127:0] in_data;

  // nr=10 instance (main sequencing tests)
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] rnd_state, rnd_key, rnd_out, lrnd_out, out_data;
  logic [3:0] round_idx;
  logic [1919:0] wfull10;
  logic [1407:0] w10;

  // nr=12 and nr=14 instances (known-answer latency tests)
  logic in_valid12, in_ready12, out_valid12, out_ready12, busy12;
  logic [127:0] rnd_state12, rnd_key12, rnd_out12, lrnd_out12, out_data12;
  logic [3:0] round_idx12;
  logic [1919:0] wfull12;
  logic [1663:0] w12;
  logic in_valid14, in_ready14, out_valid14, out_ready14, busy14;
  logic [127:0] rnd_state14, rnd_key14, rnd_out14, lrnd_out14, out_data14;
  logic [3:0] round_idx14;
  logic [1919:0] wfull14;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  // S-box from first principles: GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, base, e;
    r = 8'h01; base = x; e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r ^ rol8(r, 1) ^ rol8(r, 2) ^ rol8(r, 3) ^ rol8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [7:0] b [16];
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = b[r + 4*((c + r) % 4)];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k);
    return mix(sub_shift(s)) ^ k;
  endfunction

  function automatic logic [127:0] aes_last(input logic [127:0] s, input logic [127:0] k);
    return sub_shift(s) ^ k;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  // Key schedule; key is top-aligned in 256 bits, result has round r at [r*128 +: 128].
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0] wd [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1919:0] res;
    int nw;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    res = '0;
    for (int i = 0; i < 60; i++) wd[i] = '0;
    for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = wd[i-1];
      if (i % nk == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      wd[i] = wd[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) res[(i/4)*128 + (3 - i%4)*32 +: 32] = wd[i];
    return res;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [1919:0] wf,
                                               input int nr);
    logic [127:0] s;
    s = pt ^ wf[127:0];
    for (int r = 1; r < nr; r++) s = aes_round(s, wf[r*128 +: 128]);
    return aes_last(s, wf[nr*128 +: 128]);
  endfunction

  assign w10 = wfull10[1407:0];
  assign w12 = wfull12[1663:0];
  assign rnd_out    = aes_round(rnd_state, rnd_key);
  assign lrnd_out   = aes_last(rnd_state, rnd_key);
  assign rnd_out12  = aes_round(rnd_state12, rnd_key12);
  assign lrnd_out12 = aes_last(rnd_state12, rnd_key12);
  assign rnd_out14  = aes_round(rnd_state14, rnd_key14);
  assign lrnd_out14 = aes_last(rnd_state14, rnd_key14);

  aes_round_sequencer #(.nk(4), .nr(10)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w(w10), .rnd_state(rnd_state), .rnd_key(rnd_key), .rnd_out(rnd_out),
    .lrnd_out(lrnd_out), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .round_idx(round_idx)
  );

  aes_round_sequencer #(.nk(6), .nr(12)) dut12 (
    .clk(clk), .reset(reset), .in_valid(in_valid12), .in_ready(in_ready12), .in_data(in_data),
    .w(w12), .rnd_state(rnd_state12), .rnd_key(rnd_key12), .rnd_out(rnd_out12),
    .lrnd_out(lrnd_out12), .out_valid(out_valid12), .out_ready(out_ready12),
    .out_data(out_data12), .busy(busy12), .round_idx(round_idx12)
  );

  aes_round_sequencer #(.nk(8), .nr(14)) dut14 (
    .clk(clk), .reset(reset), .in_valid(in_valid14), .in_ready(in_ready14), .in_data(in_data),
    .w(wfull14), .rnd_state(rnd_state14), .rnd_key(rnd_key14), .rnd_out(rnd_out14),
    .lrnd_out(lrnd_out14), .out_valid(out_valid14), .out_ready(out_ready14),
    .out_data(out_data14), .busy(busy14), .round_idx(round_idx14)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a block, wait for acceptance, then count cycles until out_valid.
  task automatic start_and_wait(input logic [127:0] pt, output int lat, output logic [127:0] ct);
    int t;
    t = 0;
    in_data = pt;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin tick(); t++; end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    ct = out_data;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_out_valid", 128'(out_valid), 128'(0));
    check("release_in_ready", 128'(in_ready), 128'(1));
  endtask

  typedef struct packed {
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
  } vec_t;

  initial begin
    vec_t tbl [3];
    logic [127:0] ct, ct12, ct14, pts [3], exp_ct;
    logic [127:0] got [$];
    int lat, lat12, lat14, t, acc_n, highs;
    int acc_t [3];
    logic take;

    tbl[0] = '{{128'h000102030405060708090a0b0c0d0e0f, 128'h0},
               128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10};
    tbl[1] = '{{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
               128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 10};
    tbl[2] = '{256'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 10};

    reset = 1'b1;
    in_valid = 1'b0; in_valid12 = 1'b0; in_valid14 = 1'b0;
    out_ready = 1'b0; out_ready12 = 1'b1; out_ready14 = 1'b1;
    in_data = '0;
    wfull10 = expand(tbl[0].key, 4);
    wfull12 = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    wfull14 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    repeat (2) tick();
    reset = 1'b0;

    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_out_data", out_data, 128'h0);
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_round_idx", 128'(round_idx), 128'(0));
    check("reset_rnd_state", rnd_state, 128'h0);
    check("reset_rnd_key", rnd_key, w10[127:0]);

    // AES-192 / AES-256 known answers and latency
    in_data = tbl[0].pt;
    in_valid12 = 1'b1; in_valid14 = 1'b1;
    tick();
    in_valid12 = 1'b0; in_valid14 = 1'b0;
    lat12 = 0; lat14 = 0; ct12 = '0; ct14 = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (out_valid12 && lat12 == 0) begin lat12 = c; ct12 = out_data12; end
      if (out_valid14 && lat14 == 0) begin lat14 = c; ct14 = out_data14; end
    end
    $display("txn nr12: ct=%h lat=%0d", ct12, lat12);
    $display("txn nr14: ct=%h lat=%0d", ct14, lat14);
    check("nr12_ct", ct12, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    check("nr12_latency", 128'(lat12), 128'(12));
    check("nr14_ct", ct14, 128'h8ea2b7ca516745bfeafc49904b496089);
    check("nr14_latency", 128'(lat14), 128'(14));

    // Table-driven AES-128 known answers
    for (int i = 0; i < 3; i++) begin
      wfull10 = expand(tbl[i].key, 4);
      start_and_wait(tbl[i].pt, lat, ct);
      $display("txn vec%0d: pt=%h ct=%h lat=%0d", i, tbl[i].pt, ct, lat);
      check("vec_ct", ct, tbl[i].ct);
      check("vec_latency", 128'(lat), 128'(tbl[i].lat));
      release_out();
    end

    // Backpressure: consumer holds off for 5 cycles
    wfull10 = expand(tbl[1].key, 4);
    start_and_wait(tbl[1].pt, lat, ct);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_out_data", out_data, tbl[1].ct);
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_busy", 128'(busy), 128'(1));
    end
    $display("txn backpressure: ct=%h", out_data);
    release_out();
    check("bp_data_held", out_data, tbl[1].ct);

    // Back-to-back: in_valid held, out_ready tied high
    wfull10 = expand(tbl[0].key, 4);
    pts[0] = 128'h00112233445566778899aabbccddeeff;
    pts[1] = 128'hdeadbeefcafef00d0123456789abcdef;
    pts[2] = 128'hffffffffffffffffffffffffffffffff;
    acc_n = 0;
    for (int i = 0; i < 3; i++) acc_t[i] = 0;
    out_ready = 1'b1;
    in_data = pts[0];
    in_valid = 1'b1;
    for (int c = 0; c < 48; c++) begin
      take = in_valid && in_ready;
      if (out_valid) got.push_back(out_data);
      tick();
      if (take) begin
        acc_t[acc_n] = c;
        acc_n++;
        if (acc_n < 3) in_data = pts[acc_n];
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("b2b_accepts", 128'(acc_n), 128'(3));
    check("b2b_spacing_1", 128'(acc_t[1] - acc_t[0]), 128'(12));
    check("b2b_spacing_2", 128'(acc_t[2] - acc_t[1]), 128'(12));
    check("b2b_out_count", 128'(got.size()), 128'(3));
    for (int i = 0; i < 3; i++) begin
      exp_ct = aes_encrypt(pts[i], wfull10, 10);
      $display("txn b2b%0d: pt=%h ct=%h", i, pts[i], (i < got.size()) ? got[i] : 128'h0);
      check("b2b_ct", (i < got.size()) ? got[i] : 128'h0, exp_ct);
    end

    // Reset while round_idx == 5 aborts the block
    in_data = tbl[0].pt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    t = 0;
    while (round_idx != 4'd5 && t < 20) begin tick(); t++; end
    check("abort_reached_round5", 128'(round_idx), 128'(5));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_in_ready", 128'(in_ready), 128'(1));
    check("abort_out_valid", 128'(out_valid), 128'(0));
    check("abort_out_data", out_data, 128'h0);
    check("abort_round_idx", 128'(round_idx), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    highs = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (out_valid) highs++;
    end
    check("abort_no_output", 128'(highs), 128'(0));
    wfull10 = expand(tbl[2].key, 4);
    start_and_wait(tbl[2].pt, lat, ct);
    $display("txn after_abort: ct=%h lat=%0d", ct, lat);
    check("abort_fresh_ct", ct, tbl[2].ct);
    check("abort_fresh_latency", 128'(lat), 128'(10));
    release_out();

    // round_idx sequence with spurious in_valid in ROUND and DONE
    wfull10 = expand(tbl[0].key, 4);
    in_data = tbl[0].pt;
    check("seq_idx_idle", 128'(round_idx), 128'(0));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      check("seq_round_idx", 128'(round_idx), 128'((k + 1 > 10) ? 10 : k + 1));
      if (k == 3 || k == 10) begin
        in_valid = 1'b1;
        in_data = ~tbl[0].pt;
      end else begin
        in_valid = 1'b0;
      end
      if (k < 10) tick();
    end
    tick();
    in_valid = 1'b0;
    $display("txn spurious: ct=%h", out_data);
    check("seq_ct", out_data, tbl[0].ct);
    check("seq_done_in_ready", 128'(in_ready), 128'(0));
    release_out();
    repeat (3) tick();
    check("seq_no_extra_accept", 128'(busy), 128'(0));
    check("seq_data_kept", out_data, tbl[0].ct);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
